// File: rtl/alu_result_stage_pkg.sv
// Shared constants and types for the ALU result stage and the condition evaluator.
// The PSR_BYPASS_EN build option is consumed by alu_result_stage.sv.
package alu_result_stage_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned PSR_W      = 5;
  localparam int unsigned COND_W     = 4;

  // PSR bit positions, ordered {C,L,F,Z,N}
  localparam int unsigned FLAG_C = 4;
  localparam int unsigned FLAG_L = 3;
  localparam int unsigned FLAG_F = 2;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 0;

  localparam logic [COND_W-1:0] COND_EQ = 4'd0;
  localparam logic [COND_W-1:0] COND_NE = 4'd1;
  localparam logic [COND_W-1:0] COND_CS = 4'd2;
  localparam logic [COND_W-1:0] COND_CC = 4'd3;
  localparam logic [COND_W-1:0] COND_HI = 4'd4;
  localparam logic [COND_W-1:0] COND_LS = 4'd5;
  localparam logic [COND_W-1:0] COND_GT = 4'd6;
  localparam logic [COND_W-1:0] COND_LE = 4'd7;
  localparam logic [COND_W-1:0] COND_FS = 4'd8;
  localparam logic [COND_W-1:0] COND_FC = 4'd9;
  localparam logic [COND_W-1:0] COND_LO = 4'd10;
  localparam logic [COND_W-1:0] COND_HS = 4'd11;
  localparam logic [COND_W-1:0] COND_LT = 4'd12;
  localparam logic [COND_W-1:0] COND_GE = 4'd13;
  localparam logic [COND_W-1:0] COND_UC = 4'd14;
  localparam logic [COND_W-1:0] COND_NV = 4'd15;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [REG_ADDR_W-1:0] addr;
    logic                  we;
  } wb_entry_t;

  // Masked PSR update: bits with we set take the new flag, others keep their value
  function automatic logic [PSR_W-1:0] psr_merge(input logic [PSR_W-1:0] psr,
                                                 input logic [PSR_W-1:0] flags,
                                                 input logic [PSR_W-1:0] we);
    return (psr & ~we) | (flags & we);
  endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// ALU-to-writeback bus of the result stage, plus PSR and condition-code taps.
interface alu_result_stage_if;

  logic                                         in_valid;
  logic                                         in_ready;
  logic [alu_result_stage_pkg::DATA_WIDTH-1:0]  alu_out;
  logic [alu_result_stage_pkg::PSR_W-1:0]       alu_flags;
  logic [alu_result_stage_pkg::PSR_W-1:0]       flag_we;
  logic [alu_result_stage_pkg::REG_ADDR_W-1:0]  rd_addr;
  logic                                         rd_we;
  logic                                         flush;
  logic                                         wb_valid;
  logic                                         wb_ready;
  logic [alu_result_stage_pkg::DATA_WIDTH-1:0]  wb_data;
  logic [alu_result_stage_pkg::REG_ADDR_W-1:0]  wb_addr;
  logic                                         wb_we;
  logic [alu_result_stage_pkg::PSR_W-1:0]       psr;
  logic [alu_result_stage_pkg::COND_W-1:0]      cond;
  logic                                         cond_true;

  // master: ALU / writeback / branch side
  modport master (
    output in_valid, alu_out, alu_flags, flag_we, rd_addr, rd_we, flush, wb_ready, cond,
    input  in_ready, wb_valid, wb_data, wb_addr, wb_we, psr, cond_true
  );

  // slave: the result stage itself
  modport slave (
    input  in_valid, alu_out, alu_flags, flag_we, rd_addr, rd_we, flush, wb_ready, cond,
    output in_ready, wb_valid, wb_data, wb_addr, wb_we, psr, cond_true
  );

endinterface

// File: rtl/alu_result_stage_cond_eval.sv
// Combinational branch/jump condition evaluator over the {C,L,F,Z,N} PSR.
module cond_eval
  import alu_result_stage_pkg::*;
(
  input  logic [PSR_W-1:0]  psr,
  input  logic [COND_W-1:0] cond,
  output logic              cond_true
);

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_EQ: cond_true =  psr[FLAG_Z];
      COND_NE: cond_true = !psr[FLAG_Z];
      COND_CS: cond_true =  psr[FLAG_C];
      COND_CC: cond_true = !psr[FLAG_C];
      COND_HI: cond_true =  psr[FLAG_L];
      COND_LS: cond_true = !psr[FLAG_L];
      COND_GT: cond_true =  psr[FLAG_N];
      COND_LE: cond_true = !psr[FLAG_N];
      COND_FS: cond_true =  psr[FLAG_F];
      COND_FC: cond_true = !psr[FLAG_F];
      COND_LO: cond_true = !psr[FLAG_L] && !psr[FLAG_Z];
      COND_HS: cond_true =  psr[FLAG_L] ||  psr[FLAG_Z];
      COND_LT: cond_true = !psr[FLAG_N] && !psr[FLAG_Z];
      COND_GE: cond_true =  psr[FLAG_N] ||  psr[FLAG_Z];
      COND_UC: cond_true = 1'b1;
      COND_NV: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_result_stage.sv
// One-entry registered ALU result stage with PSR maintenance and condition evaluation.
// Build option PSR_BYPASS_EN: condition codes see this cycle's accepted flag update.
module alu_result_stage
  import alu_result_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  alu_result_stage_if.slave  bus
);

  logic             wb_valid_q;
  logic             wb_valid_d;
  wb_entry_t        wb_q;
  wb_entry_t        wb_d;
  logic [PSR_W-1:0] psr_q;
  logic [PSR_W-1:0] psr_d;
  logic [PSR_W-1:0] psr_eval;
  logic             in_ready_c;
  logic             acc_c;

  assign in_ready_c = !wb_valid_q || bus.wb_ready;
  assign acc_c      = bus.in_valid && in_ready_c && !bus.flush;

  // Next-state: flush wins, then accept (replaces any draining entry), then drain
  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_d       = wb_q;
    psr_d      = psr_q;
    if (bus.flush) begin
      wb_valid_d = 1'b0;
    end else if (acc_c) begin
      wb_valid_d = 1'b1;
      wb_d       = '{data: bus.alu_out, addr: bus.rd_addr, we: bus.rd_we};
      psr_d      = psr_merge(psr_q, bus.alu_flags, bus.flag_we);
    end else if (bus.wb_ready) begin
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_q       <= '0;
      psr_q      <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_q       <= wb_d;
      psr_q      <= psr_d;
    end
  end

`ifdef PSR_BYPASS_EN
  assign psr_eval = psr_d;
`else
  assign psr_eval = psr_q;
`endif

  cond_eval u_cond_eval (
    .psr       (psr_eval),
    .cond      (bus.cond),
    .cond_true (bus.cond_true)
  );

  assign bus.in_ready = in_ready_c;
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_data  = wb_q.data;
  assign bus.wb_addr  = wb_q.addr;
  assign bus.wb_we    = wb_q.we;
  assign bus.psr      = psr_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus randomized traffic
// against a transaction-level model of the one-entry stage and PSR.
module tb_alu_result_stage;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  alu_result_stage_if bus ();

  alu_result_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic        m_valid;
  logic [15:0] m_data;
  logic [3:0]  m_addr;
  logic        m_we;
  logic [4:0]  m_psr;

`ifdef PSR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Condition truth from PSR {C,L,F,Z,N}: codes 0-9 are flag/inverse pairs
  function automatic logic ref_cond(input logic [4:0] p, input logic [3:0] c);
    logic fc, fl, ff, fz, fn;
    logic [4:0] pairs;
    {fc, fl, ff, fz, fn} = p;
    pairs = {ff, fn, fl, fc, fz};
    if (c < 4'd10) return pairs[c[3:1]] ^ c[0];
    if (c == 4'd10) return !fl && !fz;
    if (c == 4'd11) return fl || fz;
    if (c == 4'd12) return !fn && !fz;
    if (c == 4'd13) return fn || fz;
    return c == 4'd14;
  endfunction

  function automatic logic model_acc();
    return bus.in_valid && (!m_valid || bus.wb_ready) && !bus.flush;
  endfunction

  function automatic logic [4:0] model_next_psr();
    logic [4:0] p;
    p = m_psr;
    if (model_acc())
      for (int i = 0; i < 5; i++)
        if (bus.flag_we[i]) p[i] = bus.alu_flags[i];
    return p;
  endfunction

  function automatic logic model_cond();
    return ref_cond(BYPASS ? model_next_psr() : m_psr, bus.cond);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_addr = '0; m_we = 1'b0; m_psr = '0;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic [4:0] f,
                       input logic [4:0] fw, input logic [3:0] a, input logic we,
                       input logic fl, input logic wr, input logic [3:0] c);
    bus.in_valid = v;  bus.alu_out = d;  bus.alu_flags = f; bus.flag_we = fw;
    bus.rd_addr = a;   bus.rd_we = we;   bus.flush = fl;    bus.wb_ready = wr;
    bus.cond = c;
  endtask

  // Advance one clock; model updates from the inputs held across the edge
  task automatic tick();
    logic       acc;
    logic [4:0] np;
    acc = model_acc();
    np  = model_next_psr();
    @(posedge clk);
    if (bus.flush) m_valid = 1'b0;
    else if (acc) begin
      m_valid = 1'b1; m_data = bus.alu_out; m_addr = bus.rd_addr; m_we = bus.rd_we;
    end else if (bus.wb_ready) m_valid = 1'b0;
    m_psr = np;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 16'h0, 5'h0, 5'h0, 4'h0, 0, 0, 0, 4'd0);
    model_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL reset_wb_valid got=%b exp=0", bus.wb_valid); end
    n_cmp++; if (bus.psr !== 5'b0) begin n_err++; $display("FAIL reset_psr got=%b exp=00000", bus.psr); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    n_cmp++; if ({bus.wb_data, bus.wb_addr, bus.wb_we} !== 21'h0) begin n_err++;
      $display("FAIL reset_wb_regs got=%h/%h/%b exp=0/0/0", bus.wb_data, bus.wb_addr, bus.wb_we); end
    rst_n = 1'b1;
    @(negedge clk);
    // Fill the stage and set flags, then reset asynchronously mid-cycle
    drive(1, 16'hBEEF, 5'b10101, 5'b11111, 4'h7, 1, 0, 0, 4'd0);
    tick();
    drive(0, 16'h0, 5'h0, 5'h0, 4'h0, 0, 0, 0, 4'd0);
    n_cmp++; if (bus.wb_valid !== 1'b1) begin n_err++; $display("FAIL prereset_wb_valid got=%b exp=1", bus.wb_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL async_reset_wb_valid got=%b exp=0", bus.wb_valid); end
    n_cmp++; if (bus.psr !== 5'b0) begin n_err++; $display("FAIL async_reset_psr got=%b exp=00000", bus.psr); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL async_reset_in_ready got=%b exp=1", bus.in_ready); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_throughput();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 16'(i), 5'h0, 5'h0, 4'(i), 1, 0, 1, 4'd14);
      #1;
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL tput_in_ready[%0d] got=%b exp=1", i, bus.in_ready); end
      tick();
      n_cmp++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 16'(i)) begin n_err++;
        $display("FAIL tput_data[%0d] got=%b/%h exp=1/%h", i, bus.wb_valid, bus.wb_data, 16'(i)); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] held;
    held = bus.wb_valid ? m_data : 16'h0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 16'h1234, 5'h1F, 5'h1F, 4'h9, 1, 0, 0, 4'd14);
      #1;
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, bus.in_ready); end
      tick();
      n_cmp++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== held) begin n_err++;
        $display("FAIL bp_hold[%0d] got=%b/%h exp=1/%h", i, bus.wb_valid, bus.wb_data, held); end
      n_cmp++; if (bus.psr !== m_psr) begin n_err++; $display("FAIL bp_psr[%0d] got=%b exp=%b", i, bus.psr, m_psr); end
    end
    // Release: the waiting 0x1234 goes in as the held entry drains
    drive(1, 16'h1234, 5'h0, 5'h0, 4'h9, 1, 0, 1, 4'd14);
    tick();
    n_cmp++; if (bus.wb_data !== 16'h1234 || bus.wb_addr !== 4'h9) begin n_err++;
      $display("FAIL bp_release got=%h/%h exp=1234/9", bus.wb_data, bus.wb_addr); end
    drive(0, 16'h0, 5'h0, 5'h0, 4'h0, 0, 0, 1, 4'd14);
    tick();
    n_cmp++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got=%b exp=0", bus.wb_valid); end
  endtask

  task automatic test_flag_mask();
    drive(1, 16'h0, 5'b00000, 5'b11111, 4'h0, 0, 0, 1, 4'd14);
    tick();
    n_cmp++; if (bus.psr !== 5'b00000) begin n_err++; $display("FAIL mask_clear got=%b exp=00000", bus.psr); end
    drive(1, 16'h0, 5'b11111, 5'b01011, 4'h0, 0, 0, 1, 4'd14);
    tick();
    n_cmp++; if (bus.psr !== 5'b01011) begin n_err++; $display("FAIL mask_psr got=%b exp=01011", bus.psr); end
    drive(0, 16'h0, 5'h0, 5'h0, 4'h0, 0, 0, 1, 4'd0);  // EQ
    #1; n_cmp++; if (bus.cond_true !== 1'b1) begin n_err++; $display("FAIL mask_cond_eq got=%b exp=1", bus.cond_true); end
    bus.cond = 4'd2;  // CS
    #1; n_cmp++; if (bus.cond_true !== 1'b0) begin n_err++; $display("FAIL mask_cond_cs got=%b exp=0", bus.cond_true); end
    bus.cond = 4'd13; // GE
    #1; n_cmp++; if (bus.cond_true !== 1'b1) begin n_err++; $display("FAIL mask_cond_ge got=%b exp=1", bus.cond_true); end
    drive(1, 16'h0, 5'b10000, 5'b00000, 4'h0, 0, 0, 1, 4'd14);  // flag_we=0 preserves all
    tick();
    n_cmp++; if (bus.psr !== 5'b01011) begin n_err++; $display("FAIL mask_zero_we got=%b exp=01011", bus.psr); end
    drive(0, 16'h0, 5'h0, 5'h0, 4'h0, 0, 0, 1, 4'd14);
    tick();
  endtask

  task automatic test_flush();
    logic [4:0] p0;
    p0 = m_psr;
    drive(1, 16'hAAAA, ~p0, 5'b11111, 4'h3, 1, 1, 1, 4'd14);
    tick();
    n_cmp++; if (bus.psr !== p0) begin n_err++; $display("FAIL flush_psr got=%b exp=%b", bus.psr, p0); end
    n_cmp++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL flush_wb_valid got=%b exp=0", bus.wb_valid); end
    // Flush of a held, stalled entry keeps stale data
    drive(1, 16'h5555, p0, 5'b00000, 4'h5, 1, 0, 0, 4'd14);
    tick();
    drive(1, 16'h6666, ~p0, 5'b11111, 4'h6, 0, 1, 0, 4'd14);
    tick();
    n_cmp++; if (bus.wb_valid !== 1'b0 || bus.wb_data !== 16'h5555) begin n_err++;
      $display("FAIL flush_held got=%b/%h exp=0/5555", bus.wb_valid, bus.wb_data); end
    n_cmp++; if (bus.psr !== p0) begin n_err++; $display("FAIL flush_held_psr got=%b exp=%b", bus.psr, p0); end
  endtask

  task automatic test_bypass();
    drive(1, 16'h0, 5'b00000, 5'b11111, 4'h0, 0, 0, 1, 4'd14);
    tick();
    drive(1, 16'h0, 5'b00010, 5'b00010, 4'h0, 0, 0, 1, 4'd0);
    #1;
    n_cmp++; if (bus.cond_true !== BYPASS) begin n_err++;
      $display("FAIL bypass_eq got=%b exp=%b", bus.cond_true, BYPASS); end
    tick();
    drive(0, 16'h0, 5'h0, 5'h0, 4'h0, 0, 0, 1, 4'd0);
    #1;
    n_cmp++; if (bus.cond_true !== 1'b1) begin n_err++; $display("FAIL bypass_after got=%b exp=1", bus.cond_true); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 16'($urandom), 5'($urandom), 5'($urandom),
            4'($urandom), 1'($urandom), 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 2) != 0), 4'($urandom));
      #1;
      n_cmp++; if (bus.in_ready !== (!m_valid || bus.wb_ready)) begin n_err++;
        $display("FAIL rnd_in_ready[%0d] got=%b exp=%b", i, bus.in_ready, !m_valid || bus.wb_ready); end
      n_cmp++; if (bus.cond_true !== model_cond()) begin n_err++;
        $display("FAIL rnd_cond[%0d] cond=%0d psr=%b got=%b exp=%b", i, bus.cond, m_psr, bus.cond_true, model_cond()); end
      tick();
      n_cmp++; if (bus.wb_valid !== m_valid || bus.psr !== m_psr) begin n_err++;
        $display("FAIL rnd_state[%0d] got=%b/%b exp=%b/%b", i, bus.wb_valid, bus.psr, m_valid, m_psr); end
      if (m_valid) begin
        n_cmp++; if ({bus.wb_data, bus.wb_addr, bus.wb_we} !== {m_data, m_addr, m_we}) begin n_err++;
          $display("FAIL rnd_wb[%0d] got=%h/%h/%b exp=%h/%h/%b", i, bus.wb_data, bus.wb_addr,
                   bus.wb_we, m_data, m_addr, m_we); end
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_throughput();
    test_backpressure();
    test_flag_mask();
    test_flush();
    test_bypass();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered stage directly downstream of the 16-bit ALU.
- Captures the ALU result and destination info into a one-entry output register toward register-file writeback, using a valid/ready handshake.
- Maintains the processor status register (PSR: C, L, F, Z, N) with per-flag write masks.
- Evaluates 4-bit branch/jump condition codes against the PSR for the fetch/branch unit.

Parameters:
- DATA_WIDTH, 16, width of ALU result and writeback data.
- REG_ADDR_W, 4, width of destination register address.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  ALU result and flags valid this cycle.
- in_ready  output  1  stage can accept; equals !wb_valid || wb_ready.
- alu_out  input  DATA_WIDTH  ALU result.
- alu_flags  input  5  {C,L,F,Z,N} from ALU.
- flag_we  input  5  per-flag PSR write mask, same bit order.
- rd_addr  input  REG_ADDR_W  destination register.
- rd_we  input  1  destination write requested.
- flush  input  1  squash current input and held output.
- wb_valid  output  1  output register holds a result.
- wb_ready  input  1  writeback consumes the result.
- wb_data  output  DATA_WIDTH  registered result.
- wb_addr  output  REG_ADDR_W  registered destination.
- wb_we  output  1  registered rd_we.
- psr  output  5  current {C,L,F,Z,N}.
- cond  input  4  condition code to evaluate.
- cond_true  output  1  condition satisfied; combinational.

Behaviour:
- Reset (async, rst_n=0): wb_valid=0, wb_data=0, wb_addr=0, wb_we=0, psr=5'b0. in_ready=1 follows from wb_valid=0. Deassertion is synchronised externally.
- Accept: acc = in_valid && in_ready && !flush.
- On acc: wb_data/wb_addr/wb_we <= alu_out/rd_addr/rd_we, and wb_valid <= 1. Latency is 1 cycle from input to wb_valid.
- Drain: wb_valid && wb_ready && !acc drives wb_valid <= 0.
- Simultaneous drain and accept: the new entry replaces the old with no bubble, giving full throughput of 1/cycle.
- Stall: while wb_valid && !wb_ready, in_ready=0. Outputs hold stable; the producer must hold its inputs.
- PSR update: on acc only, each bit i becomes psr[i] <= flag_we[i] ? alu_flags[i] : psr[i]. Non-accepted inputs never touch the PSR.
- Flush: wb_valid <= 0 and the input is not accepted, so neither PSR nor wb registers update. Flush overrides a simultaneous in_valid and wb_ready. wb_data/addr/we keep stale values.
- Condition codes, with cond_true combinational from the PSR (see feature below):
  - 0 EQ: Z.
  - 1 NE: !Z.
  - 2 CS: C.
  - 3 CC: !C.
  - 4 HI: L.
  - 5 LS: !L.
  - 6 GT: N.
  - 7 LE: !N.
  - 8 FS: F.
  - 9 FC: !F.
  - 10 LO: !L && !Z.
  - 11 HS: L || Z.
  - 12 LT: !N && !Z.
  - 13 GE: N || Z.
  - 14 UC: 1.
  - 15 NV: 0.
- Widths: no arithmetic is performed; data passes through unmodified. flag_we=0 is legal and preserves all PSR bits.

Optional Feature:
- Macro: PSR_BYPASS_EN.
- Defined: cond_true evaluates the next-PSR value, i.e. with this cycle's masked update applied when acc=1. A branch immediately after a compare therefore sees fresh flags in the same cycle.
- Undefined: cond_true evaluates the registered psr only, so flags are visible one cycle after acceptance.

Decomposition:
- Shared package holds:
  - Flag bit index constants: FLAG_C=4, FLAG_L=3, FLAG_F=2, FLAG_Z=1, FLAG_N=0.
  - The 16 condition-code constants (COND_EQ..COND_NV).
  - PSR width 5.
- One natural sub-module, cond_eval: purely combinational; psr[4:0] and cond[3:0] in, cond_true out. It is reused by the branch unit.

Test Plan:
1. Reset: assert rst_n=0 mid-stream with wb_valid=1 → wb_valid=0, psr=0 immediately (async), in_ready=1.
2. Throughput: in_valid=1 and wb_ready=1 for 4 cycles, alu_out=1,2,3,4 → wb_data=1,2,3,4 on consecutive cycles, no bubbles.
3. Backpressure: wb_ready=0 with wb_valid=1 → in_ready=0; in_valid with alu_out=0x1234 is not accepted, and wb_data holds its prior value until wb_ready=1.
4. Flag mask: psr=0, accept alu_flags=5'b11111 with flag_we=5'b01011 → psr=5'b01011; cond=EQ → 1, CS → 0, GE → 1.
5. Flush: in_valid=1, flush=1, flag_we=5'b11111 → psr unchanged, wb_valid=0 next cycle.
6. Bypass: accept compare with Z=1 (flag_we Z set) and cond=EQ in the same cycle → cond_true=1 with PSR_BYPASS_EN defined, 0 without (psr previously 0).
